game_level_sequencer: RTL

Top-level game-flow controller that produces the 2-bit `levelCode` consumed by the four-way background bitmap mux: LEVEL_ONE=00, LEVEL_TWO=01, WIN=10, GAME_OVER=11. It sequences level intro freezes, gameplay, level advance, life loss, and the end-screen hold/restart. It also drives the gameplay enable and the one-cycle control pulses used by object and score logic.

---
 rtl/game_level_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/game_level_sequencer.sv
// game_level_sequencer: game-flow controller for level intro, play, advance,
// life loss and end-screen hold/restart.
// Ports:
//   clk, reset (async, active-high)
//   levelDone, playerHit, startKey (level-sensitive inputs; startKey acts on its rising edge)
//   levelCode (00 L1, 01 L2, 10 WIN, 11 GAME_OVER), gameEnable,
//   levelStartPulse, lifeLostPulse, livesLeft
module game_level_sequencer #(
   parameter int LIVES_INIT   = 3,
   parameter int INTRO_CYCLES = 50_000_000,
   parameter int HOLD_CYCLES  = 100_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       levelDone,
   input  logic       playerHit,
   input  logic       startKey,
   output logic [1:0] levelCode,
   output logic       gameEnable,
   output logic       levelStartPulse,
   output logic       lifeLostPulse,
   output logic [2:0] livesLeft
);

   localparam int MAXC = (INTRO_CYCLES > HOLD_CYCLES) ? INTRO_CYCLES : HOLD_CYCLES;
   localparam int CW   = $clog2(MAXC) + 1;

   localparam logic [CW-1:0] INTRO_LAST = CW'(INTRO_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
   localparam logic [2:0]    LIVES_RST  = 3'(LIVES_INIT);

   typedef enum logic [2:0] {
      L1_INTRO  = 3'd0,
      L1_PLAY   = 3'd1,
      L2_INTRO  = 3'd2,
      L2_PLAY   = 3'd3,
      WIN_HOLD  = 3'd4,
      WIN_WAIT  = 3'd5,
      OVER_HOLD = 3'd6,
      OVER_WAIT = 3'd7
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          key_prev;
   logic          key_rise;

   assign key_rise = startKey & ~key_prev;

   // Outputs are registered together with the state, so every branch
   // loads the output values belonging to the state being entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= L1_INTRO;
         cnt             <= '0;
         key_prev        <= 1'b0;
         livesLeft       <= LIVES_RST;
         levelCode       <= 2'b00;
         gameEnable      <= 1'b0;
         levelStartPulse <= 1'b0;
         lifeLostPulse   <= 1'b0;
      end else begin
         key_prev        <= startKey;
         levelStartPulse <= 1'b0;
         lifeLostPulse   <= 1'b0;
         case (state)
            L1_INTRO, L2_INTRO: begin
               if (cnt == INTRO_LAST) begin
                  state           <= (state == L1_INTRO) ? L1_PLAY : L2_PLAY;
                  cnt             <= '0;
                  gameEnable      <= 1'b1;
                  levelStartPulse <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            L1_PLAY, L2_PLAY: begin
               cnt <= '0;
               // A hit outranks a level completion in the same cycle.
               if (playerHit) begin
                  gameEnable    <= 1'b0;
                  lifeLostPulse <= 1'b1;
                  if (livesLeft > 3'd1) begin
                     livesLeft <= livesLeft - 3'd1;
                     state     <= (state == L1_PLAY) ? L1_INTRO : L2_INTRO;
                  end else begin
                     livesLeft <= 3'd0;
                     state     <= OVER_HOLD;
                     levelCode <= 2'b11;
                  end
               end else if (levelDone) begin
                  gameEnable <= 1'b0;
                  if (state == L1_PLAY) begin
                     state     <= L2_INTRO;
                     levelCode <= 2'b01;
                  end else begin
                     state     <= WIN_HOLD;
                     levelCode <= 2'b10;
                  end
               end
            end
            WIN_HOLD, OVER_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  state <= (state == WIN_HOLD) ? WIN_WAIT : OVER_WAIT;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WIN_WAIT, OVER_WAIT: begin
               cnt <= '0;
               if (key_rise) begin
                  state     <= L1_INTRO;
                  livesLeft <= LIVES_RST;
                  levelCode <= 2'b00;
               end
            end
            default: begin
               state      <= L1_INTRO;
               cnt        <= '0;
               levelCode  <= 2'b00;
               gameEnable <= 1'b0;
            end
         endcase
      end
   end

endmodule
